pd_trace_buffer: RTL and testbench

//   Parametrised on-chip trace capture for the pipeline probes. Samples NCH probe channels
//   (one per stage, e.g. F, D, X...) each cycle, arbitrates them into a DEPTH-entry FIFO,
//   and drains records over a valid/ready port.

---
 rtl/pd_trace_buffer_if.sv | 35 +++
 rtl/pd_trace_buffer.sv | 194 +++++++++++++++++++
 tb/tb_pd_trace_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_trace_buffer_if.sv
// Trace record drain port of pd_trace_buffer: FIFO head plus valid/ready handshake.
// master = the trace buffer (producer), slave = the consumer draining records.
interface pd_trace_buffer_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int CW  = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [AW-1:0]  out_pc;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_stamp;

  modport master (
    output out_valid,
    output out_ch,
    output out_pc,
    output out_data,
    output out_stamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ch,
    input  out_pc,
    input  out_data,
    input  out_stamp,
    output out_ready
  );
endinterface

// File: rtl/pd_trace_buffer.sv
// On-chip pipeline trace capture: per-channel hold registers, round-robin arbitration
// into a DEPTH-entry FIFO, free-run / PC-trigger capture with stop-after-N and drop counting.
module pd_trace_buffer #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         ch_valid,
  input  logic [NCH*AW-1:0]      ch_pc,
  input  logic [NCH*DW-1:0]      ch_data,
  input  logic                   mode,
  input  logic [AW-1:0]          trig_pc,
  input  logic [CW-1:0]          stop_count,
  input  logic                   arm,
  pd_trace_buffer_if.master      trace,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] level,
  output logic [CW-1:0]          drop_count
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t st, st_nxt;

  logic [CW-1:0]  cyc;
  logic [CW-1:0]  cap_cnt;
  logic [CW-1:0]  cap_inc;
  logic [CW-1:0]  drop_nxt;
  logic [CHW-1:0] rr;

  logic [NCH-1:0] hold_v;
  logic [AW-1:0]  hold_pc    [NCH];
  logic [DW-1:0]  hold_data  [NCH];
  logic [CW-1:0]  hold_stamp [NCH];

  logic [NCH-1:0] match;
  logic [NCH-1:0] sample;
  logic [NCH-1:0] granted;
  logic [NCH-1:0] load;
  logic [NCH-1:0] drop;
  logic           grant_any;
  logic [CHW-1:0] grant_idx;
  logic           flush;
  logic           push;
  logic           pop;
  logic           full;
  logic           head_valid;

  logic [CHW-1:0] mem_ch    [DEPTH];
  logic [AW-1:0]  mem_pc    [DEPTH];
  logic [DW-1:0]  mem_data  [DEPTH];
  logic [CW-1:0]  mem_stamp [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      match[i] = ch_valid[i] && (ch_pc[i*AW +: AW] == trig_pc);
    end
  end

  // Round-robin: first pass covers rr..NCH-1, second pass wraps to 0..rr-1.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_any && hold_v[i] && (CHW'(i) >= rr)) begin
        grant_any = 1'b1;
        grant_idx = CHW'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_any && hold_v[i]) begin
        grant_any = 1'b1;
        grant_idx = CHW'(i);
      end
    end
  end

  assign head_valid = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop        = head_valid && trace.out_ready;
  assign push       = (st == S_CAPTURE) && grant_any && (!full || pop);
  assign cap_inc    = cap_cnt + CW'(push);

  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= S_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // The edge that completes the capture samples nothing and flushes the holds.
  always_comb begin
    st_nxt = st;
    flush  = 1'b0;
    sample = '0;
    case (st)
      S_IDLE, S_DONE: if (arm) st_nxt = S_ARMED;
      S_ARMED:        if (!mode || (|match)) st_nxt = S_CAPTURE;
      S_CAPTURE:      if ((stop_count != '0) && (cap_inc >= stop_count)) st_nxt = S_DONE;
      default:        st_nxt = S_IDLE;
    endcase
    flush = (st == S_CAPTURE) && (st_nxt == S_DONE);
    if (st == S_CAPTURE && !flush) begin
      sample = ch_valid;
    end else if (st == S_ARMED && mode) begin
      sample = match;
    end
  end

  always_comb begin
    granted = '0;
    if (push) granted[grant_idx] = 1'b1;
    load     = sample & (~hold_v | granted);
    drop     = sample & hold_v & ~granted;
    drop_nxt = drop_count;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (drop[i] && (drop_nxt != '1)) drop_nxt = drop_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc        <= '0;
      cap_cnt    <= '0;
      rr         <= '0;
      hold_v     <= '0;
      drop_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      cyc        <= cyc + CW'(1);
      drop_count <= drop_nxt;
      if ((st == S_IDLE || st == S_DONE) && arm) begin
        cap_cnt <= '0;
      end else if (push) begin
        cap_cnt <= cap_inc;
      end
      if (push) begin
        rr     <= (grant_idx == CHW'(NCH-1)) ? '0 : grant_idx + CHW'(1);
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
      for (int unsigned i = 0; i < NCH; i++) begin
        if (flush) begin
          hold_v[i] <= 1'b0;
        end else if (load[i]) begin
          hold_v[i] <= 1'b1;
        end else if (granted[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (load[i]) begin
        hold_pc[i]    <= ch_pc[i*AW +: AW];
        hold_data[i]  <= ch_data[i*DW +: DW];
        hold_stamp[i] <= cyc;
      end
    end
    if (push) begin
      mem_ch[wr_ptr[PW-1:0]]    <= grant_idx;
      mem_pc[wr_ptr[PW-1:0]]    <= hold_pc[grant_idx];
      mem_data[wr_ptr[PW-1:0]]  <= hold_data[grant_idx];
      mem_stamp[wr_ptr[PW-1:0]] <= hold_stamp[grant_idx];
    end
  end

  assign trace.out_valid = head_valid;
  assign trace.out_ch    = head_valid ? mem_ch[rd_ptr[PW-1:0]]    : '0;
  assign trace.out_pc    = head_valid ? mem_pc[rd_ptr[PW-1:0]]    : '0;
  assign trace.out_data  = head_valid ? mem_data[rd_ptr[PW-1:0]]  : '0;
  assign trace.out_stamp = head_valid ? mem_stamp[rd_ptr[PW-1:0]] : '0;

  assign state = st;
  assign level = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_pd_trace_buffer.sv
// Directed bench for pd_trace_buffer: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_pd_trace_buffer;
  localparam int NCH   = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  typedef struct {
    bit          v;
    int unsigned ch;
    logic [31:0] pc;
    logic [31:0] data;
    int unsigned stamp;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_valid;
  logic [63:0] ch_pc;
  logic [63:0] ch_data;
  logic        mode;
  logic [31:0] trig_pc;
  logic [15:0] stop_count;
  logic        arm;
  logic [1:0]  state;
  logic [4:0]  level;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  pd_trace_buffer_if #(.NCH(NCH), .AW(AW), .DW(DW), .CW(CW)) trace_if ();

  pd_trace_buffer #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_valid   (ch_valid),
    .ch_pc      (ch_pc),
    .ch_data    (ch_data),
    .mode       (mode),
    .trig_pc    (trig_pc),
    .stop_count (stop_count),
    .arm        (arm),
    .trace      (trace_if),
    .state      (state),
    .level      (level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO as a queue, holds as optional records, state as an integer.
  rec_t        m_hold [NCH];
  rec_t        m_q [$];
  rec_t        m_r;
  rec_t        got [$];
  int          m_state, m_nst, m_g, m_c;
  int unsigned m_cyc, m_cap, m_drop, m_rr;
  bit          m_pop, m_push, m_trig, m_take;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_cyc = 0; m_cap = 0; m_drop = 0; m_rr = 0;
      m_q.delete();
      for (int i = 0; i < NCH; i++) m_hold[i].v = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_pop = (m_q.size() > 0) && trace_if.out_ready;
      m_g = -1;
      for (int k = 0; k < NCH; k++) begin
        m_c = (m_rr + k) % NCH;
        if (m_g < 0 && m_hold[m_c].v) m_g = m_c;
      end
      m_push = (m_state == 2) && (m_g >= 0) && ((m_q.size() < DEPTH) || m_pop);
      m_trig = 1'b0;
      for (int i = 0; i < NCH; i++)
        if (ch_valid[i] && ch_pc[i*AW +: AW] == trig_pc) m_trig = 1'b1;
      m_nst = m_state;
      if ((m_state == 0 || m_state == 3) && arm) begin
        m_nst = 1; m_cap = 0;
      end else if (m_state == 1 && (!mode || m_trig)) begin
        m_nst = 2;
      end else if (m_state == 2 && stop_count != 0 && (m_cap + m_push) >= stop_count) begin
        m_nst = 3;
      end
      if (m_pop) m_r = m_q.pop_front();
      if (m_push) begin
        m_q.push_back(m_hold[m_g]);
        m_hold[m_g].v = 1'b0;
        m_rr = (m_g + 1) % NCH;
        m_cap++;
      end
      for (int i = 0; i < NCH; i++) begin
        m_take = ch_valid[i] && ((m_state == 2 && m_nst == 2) ||
                                 (m_state == 1 && mode && ch_pc[i*AW +: AW] == trig_pc));
        if (m_state == 2 && m_nst == 3) begin
          m_hold[i].v = 1'b0;
        end else if (m_take) begin
          if (m_hold[i].v) begin
            if (m_drop < (1 << CW) - 1) m_drop++;
          end else begin
            m_hold[i].v     = 1'b1;
            m_hold[i].ch    = i;
            m_hold[i].pc    = ch_pc[i*AW +: AW];
            m_hold[i].data  = ch_data[i*DW +: DW];
            m_hold[i].stamp = m_cyc;
          end
        end
      end
      m_cyc = (m_cyc + 1) % (1 << CW);
      m_state = m_nst;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("out_valid", trace_if.out_valid, m_q.size() > 0);
      check("state", state, m_state);
      check("level", level, m_q.size());
      check("drop_count", drop_count, m_drop);
      if (m_q.size() > 0) begin
        check("out_ch", trace_if.out_ch, m_q[0].ch);
        check("out_pc", trace_if.out_pc, m_q[0].pc);
        check("out_data", trace_if.out_data, m_q[0].data);
        check("out_stamp", trace_if.out_stamp, m_q[0].stamp);
      end
      if (reset && trace_if.out_valid && trace_if.out_ready) begin
        m_r.v = 1'b1;
        m_r.ch = trace_if.out_ch;
        m_r.pc = trace_if.out_pc;
        m_r.data = trace_if.out_data;
        m_r.stamp = trace_if.out_stamp;
        got.push_back(m_r);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    ch_valid = v;
    ch_pc    = {pc1, pc0};
    ch_data  = {pc1 ^ 32'h5A5A_0000, pc0 ^ 32'hA5A5_0000};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    tick(1);
    reset = 1'b1;
    got.delete();
  endtask

  task automatic arm_capture(input logic md);
    mode = md;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mode = 1'b0; trig_pc = '0; stop_count = '0; arm = 1'b0;
    trace_if.out_ready = 1'b1;
    drive(2'b00, 32'h0, 32'h0);
    tick(2);
    check("rst_state", state, 0);
    check("rst_level", level, 0);
    check("rst_valid", trace_if.out_valid, 0);
    check("rst_drop", drop_count, 0);
    check("rst_out_pc", trace_if.out_pc, 0);
    reset = 1'b1;
    got.delete();

    // Free-run, single channel.
    arm_capture(1'b0);
    check("t1_state_capture", state, 2);
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 32'h0100_0000 + 32'(4*k), 32'h0);
      tick(1);
    end
    drive(2'b00, 32'h0, 32'h0);
    tick(6);
    check("t1_count", got.size(), 4);
    if (got.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t1_pc", got[k].pc, 32'h0100_0000 + 32'(4*k));
        check("t1_ch", got[k].ch, 0);
      end
      check("t1_stamp_step", got[3].stamp - got[2].stamp, 1);
      check("t1_stamp_step0", got[1].stamp - got[0].stamp, 1);
    end
    check("t1_drop", drop_count, 0);

    // PC trigger.
    do_reset();
    trig_pc = 32'h0100_0008;
    mode = 1'b1;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    check("t2_armed", state, 1);
    drive(2'b01, 32'h0100_0000, 32'h0); tick(1);
    drive(2'b01, 32'h0100_0004, 32'h0); tick(1);
    check("t2_still_armed", state, 1);
    drive(2'b01, 32'h0100_0008, 32'h0); tick(1);
    check("t2_triggered", state, 2);
    drive(2'b01, 32'h0100_000C, 32'h0); tick(1);
    drive(2'b00, 32'h0, 32'h0);
    tick(5);
    check("t2_count", got.size(), 2);
    if (got.size() == 2) begin
      check("t2_first_pc", got[0].pc, 32'h0100_0008);
      check("t2_second_pc", got[1].pc, 32'h0100_000C);
    end

    // Both channels every cycle: alternating grants, one drop per cycle.
    do_reset();
    arm_capture(1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 32'h2000 + 32'(4*k), 32'h3000 + 32'(4*k));
      tick(1);
    end
    drive(2'b00, 32'h0, 32'h0);
    check("t3_drop", drop_count, 7);
    tick(6);
    check("t3_count", got.size(), 9);
    if (got.size() == 9) begin
      for (int k = 0; k < 9; k++) check("t3_alternate", got[k].ch, k % 2);
      check("t3_pc2", got[2].pc, 32'h2004);
      check("t3_pc3", got[3].pc, 32'h3008);
      check("t3_pc8", got[8].pc, 32'h201C);
    end

    // Back-pressure: FIFO fills, one record held, three dropped.
    do_reset();
    trace_if.out_ready = 1'b0;
    arm_capture(1'b0);
    for (int k = 0; k < 20; k++) begin
      drive(2'b01, 32'h4000 + 32'(4*k), 32'h0);
      tick(1);
    end
    drive(2'b00, 32'h0, 32'h0);
    check("t4_level_full", level, 16);
    check("t4_valid", trace_if.out_valid, 1);
    check("t4_drop", drop_count, 3);
    check("t4_head", trace_if.out_pc, 32'h4000);
    tick(2);
    check("t4_head_stable", trace_if.out_pc, 32'h4000);
    trace_if.out_ready = 1'b1;
    tick(22);
    check("t4_count", got.size(), 17);
    if (got.size() == 17) begin
      for (int k = 0; k < 17; k++) check("t4_order", got[k].pc, 32'h4000 + 32'(4*k));
    end
    check("t4_level_empty", level, 0);

    // Stop after three records, then re-arm.
    do_reset();
    stop_count = 16'd3;
    arm_capture(1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 32'h5000 + 32'(4*k), 32'h0);
      tick(1);
    end
    drive(2'b00, 32'h0, 32'h0);
    tick(4);
    check("t5_count", got.size(), 3);
    check("t5_done", state, 3);
    if (got.size() == 3) check("t5_last_pc", got[2].pc, 32'h5008);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    check("t5_rearmed", state, 1);
    stop_count = 16'd0;

    // Reset in the middle of a capture.
    do_reset();
    trace_if.out_ready = 1'b0;
    arm_capture(1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(2'b01, 32'h6000 + 32'(4*k), 32'h0);
      tick(1);
    end
    check("t6_level5", level, 5);
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    tick(1);
    check("t6_state_idle", state, 0);
    check("t6_level_zero", level, 0);
    check("t6_valid_zero", trace_if.out_valid, 0);
    reset = 1'b1;
    trace_if.out_ready = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
